// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the fetch address and sequences boot, advance, redirect,
// exception entry, stall-hold and halt, with IF flush/valid qualifiers decoded from state.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Halt,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        Exception,
  input  logic [31:0] ExcPC,
  output logic [31:0] PCAddress,
  output logic        FetchValid,
  output logic        FlushIF,
  output logic [31:0] EPC,
  output logic [1:0]  State
);

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StRun    = 2'd1,
    StFlush  = 2'd2,
    StHalted = 2'd3
  } state_e;

  localparam logic [1:0] FlushLoad = 2'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        halt_pend_q, halt_pend_d;

  logic        take_exc;
  logic        take_redir;
  logic [31:0] exc_epc;
  logic [31:0] redir_tgt;

  // Prioritised redirect decode; a misaligned branch/jump target becomes an exception.
  always_comb begin
    take_exc   = 1'b0;
    take_redir = 1'b0;
    exc_epc    = ExcPC;
    redir_tgt  = BranchTarget;
    if (Exception) begin
      take_exc = 1'b1;
    end else if (BranchTaken) begin
      if (BranchTarget[1:0] != 2'b00) begin
        take_exc = 1'b1;
        exc_epc  = BranchTarget;
      end else begin
        take_redir = 1'b1;
      end
    end else if (Jump) begin
      redir_tgt = JumpTarget;
      if (JumpTarget[1:0] != 2'b00) begin
        take_exc = 1'b1;
        exc_epc  = JumpTarget;
      end else begin
        take_redir = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    epc_d       = epc_q;
    cnt_d       = cnt_q;
    halt_pend_d = halt_pend_q;
    unique case (state_q)
      StBoot: begin
        state_d = StRun;
      end
      StRun: begin
        if (take_exc) begin
          epc_d       = exc_epc;
          pc_d        = EXC_VECTOR;
          cnt_d       = FlushLoad;
          halt_pend_d = 1'b0;
          state_d     = StFlush;
        end else if (take_redir) begin
          pc_d    = redir_tgt;
          cnt_d   = FlushLoad;
          state_d = StFlush;
        end else if (Halt || halt_pend_q) begin
          halt_pend_d = 1'b0;
          state_d     = StHalted;
        end else if (!Stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      StFlush: begin
        // Halt seen while flushing is remembered and taken on the first RUN edge.
        halt_pend_d = halt_pend_q | Halt;
        if (take_exc) begin
          epc_d       = exc_epc;
          pc_d        = EXC_VECTOR;
          cnt_d       = FlushLoad;
          halt_pend_d = 1'b0;
        end else if (take_redir) begin
          pc_d  = redir_tgt;
          cnt_d = FlushLoad;
        end else if (cnt_q == 2'd0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StHalted: begin
        if (Exception) begin
          epc_d   = ExcPC;
          pc_d    = EXC_VECTOR;
          cnt_d   = FlushLoad;
          state_d = StFlush;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StBoot;
      pc_q        <= RESET_VECTOR;
      epc_q       <= 32'h0;
      cnt_q       <= 2'd0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      cnt_q       <= cnt_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign PCAddress  = pc_q;
  assign EPC        = epc_q;
  assign State      = state_q;
  assign FetchValid = (state_q == StRun);
  assign FlushIF    = (state_q == StFlush);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed test-plan sequences then random events, all outputs
// compared each cycle against a cycle-level behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] EV = 32'h0000_0080;
  localparam int          FC = 2;

  localparam int M_BOOT = 0, M_RUN = 1, M_FLUSH = 2, M_HALT = 3;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0, Halt = 1'b0, BranchTaken = 1'b0, Jump = 1'b0, Exception = 1'b0;
  logic [31:0] BranchTarget = '0, JumpTarget = '0, ExcPC = '0;
  logic [31:0] PCAddress, EPC;
  logic        FetchValid, FlushIF;
  logic [1:0]  State;

  int n_checks = 0;
  int n_errors = 0;

  int          m_state;
  logic [31:0] m_pc, m_epc;
  int          m_left;
  bit          m_pend;

  pc_sequencer #(
    .RESET_VECTOR(RV),
    .EXC_VECTOR  (EV),
    .FLUSH_CYCLES(FC)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Stall       (Stall),
    .Halt        (Halt),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .Jump        (Jump),
    .JumpTarget  (JumpTarget),
    .Exception   (Exception),
    .ExcPC       (ExcPC),
    .PCAddress   (PCAddress),
    .FetchValid  (FetchValid),
    .FlushIF     (FlushIF),
    .EPC         (EPC),
    .State       (State)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_BOOT;
    m_pc    = RV;
    m_epc   = 32'h0;
    m_left  = 0;
    m_pend  = 1'b0;
  endtask

  task automatic m_exc(input logic [31:0] e);
    m_epc   = e;
    m_pc    = EV;
    m_left  = FC;
    m_pend  = 1'b0;
    m_state = M_FLUSH;
  endtask

  task automatic m_redir(input logic [31:0] t);
    m_pc    = t;
    m_left  = FC;
    m_state = M_FLUSH;
  endtask

  // One clock edge of the architectural rules, using the inputs present at the edge.
  task automatic model_edge();
    bit          exc, red;
    logic [31:0] e, t;
    exc = 0; red = 0; e = ExcPC; t = 0;
    if (Exception) exc = 1;
    else if (BranchTaken) begin
      if (BranchTarget % 4 != 0) begin exc = 1; e = BranchTarget; end
      else begin red = 1; t = BranchTarget; end
    end else if (Jump) begin
      if (JumpTarget % 4 != 0) begin exc = 1; e = JumpTarget; end
      else begin red = 1; t = JumpTarget; end
    end
    case (m_state)
      M_BOOT: m_state = M_RUN;
      M_RUN: begin
        if (exc) m_exc(e);
        else if (red) m_redir(t);
        else if (Halt || m_pend) begin m_state = M_HALT; m_pend = 0; end
        else if (!Stall) m_pc = m_pc + 32'd4;
      end
      M_FLUSH: begin
        if (Halt) m_pend = 1;
        if (exc) m_exc(e);
        else if (red) m_redir(t);
        else begin
          m_left--;
          if (m_left == 0) m_state = M_RUN;
        end
      end
      default: if (Exception) m_exc(ExcPC);
    endcase
  endtask

  task automatic compare_all();
    check_eq("pc", PCAddress, m_pc);
    check_eq("state", 32'(State), 32'(m_state));
    check_eq("valid", 32'(FetchValid), 32'(m_state == M_RUN));
    check_eq("flush", 32'(FlushIF), 32'(m_state == M_FLUSH));
    check_eq("epc", EPC, m_epc);
  endtask

  task automatic step(input logic st, input logic hl, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt, input logic ex,
                      input logic [31:0] ep);
    Stall = st; Halt = hl; BranchTaken = br; BranchTarget = bt;
    Jump = jp; JumpTarget = jt; Exception = ex; ExcPC = ep;
    @(posedge Clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #3;
    compare_all();
    check_eq("rst_pc", PCAddress, RV);
    #5 Reset = 1'b1;

    // Boot then sequential advance to 0x10
    idle(5);
    check_eq("seq_pc", PCAddress, 32'h10);

    // Stall three cycles, then resume
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    check_eq("stall_pc", PCAddress, 32'h10);
    idle(1);
    check_eq("unstall_pc", PCAddress, 32'h14);

    // Branch beats jump in the same cycle
    step(0, 0, 1, 32'h200, 1, 32'h300, 0, 0);
    check_eq("br_pc", PCAddress, 32'h200);
    check_eq("br_flush", 32'(FlushIF), 32'd1);
    idle(2);
    check_eq("br_valid", 32'(FetchValid), 32'd1);
    idle(1);
    check_eq("br_next", PCAddress, 32'h204);

    // Halt, ignore events, leave via exception
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'h500, 1, 32'h600, 0, 0);
    check_eq("halt_state", 32'(State), 32'd3);
    step(0, 0, 0, 0, 0, 0, 1, 32'h44);
    check_eq("exc_epc", EPC, 32'h44);
    check_eq("exc_pc", PCAddress, EV);
    idle(2);

    // Misaligned jump becomes an exception
    step(0, 0, 0, 0, 1, 32'h102, 0, 0);
    check_eq("mis_epc", EPC, 32'h102);
    check_eq("mis_pc", PCAddress, EV);
    idle(2);

    // Wraparound
    step(0, 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 0);
    idle(3);
    check_eq("pre_wrap", PCAddress, 32'hFFFF_FFFC);
    idle(1);
    check_eq("wrap_pc", PCAddress, 32'h0);

    // Asynchronous reset in the middle of a flush
    step(0, 0, 0, 0, 1, 32'h400, 0, 0);
    Reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_eq("arst_flush", 32'(FlushIF), 32'd0);
    #2 Reset = 1'b1;
    idle(2);

    // Random events
    for (int i = 0; i < 800; i++) begin
      logic [31:0] bt, jt;
      bt = $urandom;
      jt = $urandom;
      if ($urandom % 4 != 0) bt[1:0] = 2'b00;
      if ($urandom % 4 != 0) jt[1:0] = 2'b00;
      step(($urandom % 4) == 0, ($urandom % 20) == 0, ($urandom % 10) == 0, bt,
           ($urandom % 10) == 0, jt, ($urandom % 16) == 0, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
